// File: rtl/mux_result_demux.sv
// Receive side of the dice/traffic-light mux: demultiplexes the shared result bus,
// checks each channel for legality, counts errors and rolls, and drives a 7-seg digit.
module mux_result_demux #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       result,
  output logic [2:0]       dice_val,
  output logic             red,
  output logic             amber,
  output logic             green,
  output logic             dice_err,
  output logic             light_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] roll_count,
  output logic [6:0]       seg_n
);

  typedef enum logic {UNSYNC, TRACK} lstate_e;

  logic             sel_q, vld_q;
  logic [2:0]       res_q;
  logic [2:0]       dice_q, dice_d;
  logic [2:0]       lt_q, lt_d;
  logic             de_q, de_d, le_q, le_d;
  logic [CNT_W-1:0] err_q, err_d, roll_q, roll_d;
  lstate_e          st_q, st_d;
  logic             err_inc, roll_inc, legal;
  logic [2:0]       succ;

  always_comb begin
    legal = (res_q == 3'b100) || (res_q == 3'b110) ||
            (res_q == 3'b001) || (res_q == 3'b010);
    case (lt_q)
      3'b100:  succ = 3'b110;
      3'b110:  succ = 3'b001;
      3'b001:  succ = 3'b010;
      default: succ = 3'b100;
    endcase
  end

  always_comb begin
    dice_d   = dice_q;
    lt_d     = lt_q;
    st_d     = st_q;
    de_d     = 1'b0;
    le_d     = 1'b0;
    err_inc  = 1'b0;
    roll_inc = 1'b0;
    // vld_q suppresses a decision on the input stage's reset contents
    if (vld_q) begin
      if (!sel_q) begin
        st_d = UNSYNC;
        if (res_q inside {[3'd1:3'd6]}) begin
          dice_d   = res_q;
          roll_inc = (res_q != dice_q) && (dice_q != 3'd0);
        end else begin
          de_d    = 1'b1;
          err_inc = 1'b1;
        end
      end else begin
        case (st_q)
          UNSYNC: begin
            if (legal) begin
              lt_d = res_q;
              st_d = TRACK;
            end else begin
              le_d    = 1'b1;
              err_inc = 1'b1;
            end
          end
          default: begin
            if (!legal) begin
              le_d    = 1'b1;
              err_inc = 1'b1;
              st_d    = UNSYNC;
            end else if (res_q != lt_q) begin
              // out-of-order legal pattern is flagged but still adopted
              lt_d = res_q;
              if (res_q != succ) begin
                le_d    = 1'b1;
                err_inc = 1'b1;
              end
            end
          end
        endcase
      end
    end
    err_d  = (err_inc  && err_q  != '1) ? err_q  + CNT_W'(1) : err_q;
    roll_d = (roll_inc && roll_q != '1) ? roll_q + CNT_W'(1) : roll_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= 1'b0;
      res_q  <= 3'd0;
      vld_q  <= 1'b0;
      dice_q <= 3'd0;
      lt_q   <= 3'd0;
      de_q   <= 1'b0;
      le_q   <= 1'b0;
      err_q  <= '0;
      roll_q <= '0;
      st_q   <= UNSYNC;
    end else begin
      sel_q  <= sel;
      res_q  <= result;
      vld_q  <= 1'b1;
      dice_q <= dice_d;
      lt_q   <= lt_d;
      de_q   <= de_d;
      le_q   <= le_d;
      err_q  <= err_d;
      roll_q <= roll_d;
      st_q   <= st_d;
    end
  end

  always_comb begin
    case (dice_q)
      3'd1:    seg_n = 7'h79;
      3'd2:    seg_n = 7'h24;
      3'd3:    seg_n = 7'h30;
      3'd4:    seg_n = 7'h19;
      3'd5:    seg_n = 7'h12;
      3'd6:    seg_n = 7'h02;
      default: seg_n = 7'h7F;
    endcase
  end

  assign dice_val   = dice_q;
  assign red        = lt_q[2];
  assign amber      = lt_q[1];
  assign green      = lt_q[0];
  assign dice_err   = de_q;
  assign light_err  = le_q;
  assign err_count  = err_q;
  assign roll_count = roll_q;

endmodule

// File: doc/mux_result_demux.md
Name: mux_result_demux

Overview:
- Receive end of the dice/traffic-light multiplexer: takes the shared 3-bit `result` bus plus the same `sel`, and splits it back into a held dice value and held traffic-light outputs.
- Checks legality of each channel:
  - dice faces must be 1..6;
  - light sequence must be red -> red+amber -> green -> amber -> red.
- Counts errors and dice changes, and drives an active-low 7-segment digit for the dice.
- Sits between the mux output and the board LEDs/display.

Parameters:
- CNT_W, 8, width of the saturating error and roll counters.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sel  input  1  channel select, same signal as the mux: 0 = dice, 1 = traffic lights
- result  input  3  multiplexed bus; dice value when sel=0, {red,amber,green} when sel=1
- dice_val  output  3  last legal dice value received
- red  output  1  last legal red light
- amber  output  1  last legal amber light
- green  output  1  last legal green light
- dice_err  output  1  one-cycle pulse on illegal dice value
- light_err  output  1  one-cycle pulse on illegal light pattern or transition
- err_count  output  CNT_W  total errors, saturating
- roll_count  output  CNT_W  number of dice value changes, saturating
- seg_n  output  7  active-low segments {g,f,e,d,c,b,a} for dice_val

Behaviour:
- Reset (rst=1 at a clk edge): all outputs are set as follows, and the light FSM goes to UNSYNC.
  - dice_val=0, red=amber=green=0;
  - dice_err=light_err=0, err_count=roll_count=0;
  - seg_n=7'h7F (blank).
- Reset mid-operation has the same effect: it overrides all other activity in that cycle.
- Input stage: sel and result are registered once. All decisions use the registered copies, so outputs and pulses appear 2 clk edges after the input is applied.
- Dice channel, active when registered sel=0:
  - value 1..6: dice_val takes the value.
    - If it differs from the previous dice_val and the previous dice_val != 0, roll_count increments.
  - value 0 or 7: dice_err pulses one cycle, err_count increments, dice_val holds.
  - While sel=1 the dice outputs hold.
- Light channel, active when registered sel=1. Legal patterns {r,a,g}: 100, 110, 001, 010. Successor map: 100->110, 110->001, 001->010, 010->100.
  - FSM states: UNSYNC, TRACK. It stores the previous pattern P.
  - UNSYNC, legal pattern: load the outputs and P, go to TRACK, no error.
  - UNSYNC, illegal pattern (000, 011, 101, 111): light_err pulse, err_count++, outputs hold, stay in UNSYNC.
  - TRACK, pattern == P: hold, no error.
  - TRACK, pattern == succ(P): load the outputs and P.
  - TRACK, legal pattern but not P or succ(P): light_err pulse, err_count++, load the outputs and P (resync), stay in TRACK.
  - TRACK, illegal pattern: light_err pulse, err_count++, outputs hold, go to UNSYNC.
  - Registered sel 1->0: FSM goes to UNSYNC, light outputs hold. On return to sel=1 the first legal pattern is accepted without a transition check.
- Counters: saturate at all-ones, no wrap. An error and a roll cannot occur in the same cycle, since one channel is active per cycle.
- Only the active channel can raise an error pulse, so dice_err and light_err are mutually exclusive.
- seg_n is combinational from dice_val:
  - 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02;
  - 0 = blank 7'h7F.

Test Plan:
- Reset, then sel=0, result=3 for 3 cycles -> after 2 edges dice_val=3, seg_n=7'h30, roll_count=0, no dice_err.
- sel=0, result sequence 3,5,5,2 -> dice_val ends at 2, roll_count=2, err_count=0.
- sel=0, result=7 then 0 -> two single-cycle dice_err pulses, err_count=2, dice_val holds its prior value.
- sel=1, result 100,110,001,010,100 each held 4 cycles -> outputs follow with 2-cycle latency, light_err never asserted.
- sel=1, in TRACK at 100, then 001 -> light_err one pulse, err_count+1, green=1 (resync). Then 111 -> light_err pulse, FSM UNSYNC, outputs hold. Then 010 -> accepted with no error.
- Saturation and reset:
  - force 260 dice errors -> err_count=8'hFF;
  - assert rst for one cycle mid-sequence -> all outputs at reset values on the next edge;
  - toggle sel 1->0->1 landing on a non-successor legal pattern -> no light_err.
